seq_div_ctrl: RTL

//   Multi-cycle signed divider controller. Takes two's-complement dividend/divisor,

---
 rtl/seq_div_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seq_div_ctrl.sv
// Multi-cycle signed divider: latches operands, takes magnitudes, runs a radix-2
// restoring shift/subtract loop for WIDTH cycles, then applies the result signs.
`timescale 1ns/1ps
module seq_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_ITER  = 2'd2,
    S_FIXUP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, mag_q, mag_d, q_q, q_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh_s, r_sub_s;
  logic             fit_s, b_zero_s;

  // Most-negative input maps to 2^(WIDTH-1) as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign b_zero_s = (b_q == '0);
  assign r_sh_s   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign r_sub_s  = r_sh_s - {1'b0, mag_q};
  assign fit_s    = r_q[WIDTH] | (r_sh_s >= {1'b0, mag_q});

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mag_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_q   <= mag_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_SETUP : S_IDLE;
      S_SETUP: state_d = b_zero_s ? S_FIXUP : S_ITER;
      S_ITER:  state_d = (cnt_q == CNT_LAST) ? S_FIXUP : S_ITER;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output register updates per state
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mag_d  = mag_q;
    q_d    = q_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dbz_d  = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = dividend;
          b_d    = divisor;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_SETUP: begin
        mag_d  = abs_val(b_q);
        q_d    = abs_val(a_q);
        r_d    = '0;
        cnt_d  = '0;
        qneg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        rneg_d = a_q[WIDTH-1];
      end
      S_ITER: begin
        r_d   = fit_s ? r_sub_s : r_sh_s;
        q_d   = {q_q[WIDTH-2:0], fit_s};
        cnt_d = cnt_q + CNT_ONE;
      end
      S_FIXUP: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (b_zero_s) begin
          quot_d = {WIDTH{1'b1}};
          rem_d  = a_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = qneg_q ? -q_q : q_q;
          rem_d  = rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
          dbz_d  = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
